r_type_issue: RTL and testbench

Sequential issue/write-back sequencer that drives the combinational R-type ALU (`r_type`). It accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes opcode, funct3, funct7, rs1, rs2 and rd. It reads operands from an internal 32x32 register file, presents opcode/funct3/funct7/in1/in2 to the ALU, captures `out`, and writes the result back to rd. It is the producer side of the ALU's field/operand interface and sits between instruction fetch and the ALU.

---
 rtl/rv32_pkg.sv | 46 ++++
 rtl/rv32_regfile.sv | 36 +++
 rtl/r_type_issue.sv | 117 +++++++++++
 tb/tb_r_type_issue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I constants, field layout and FSM state encoding for the
// R-type issue sequencer.
package rv32_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] F7_BASE   = 7'h00;
   localparam logic [6:0] F7_ALT    = 7'h20;

   localparam logic [2:0] F3_ADD_SUB = 3'd0;
   localparam logic [2:0] F3_SLL     = 3'd1;
   localparam logic [2:0] F3_SLT     = 3'd2;
   localparam logic [2:0] F3_SLTU    = 3'd3;
   localparam logic [2:0] F3_XOR     = 3'd4;
   localparam logic [2:0] F3_SRL_SRA = 3'd5;
   localparam logic [2:0] F3_OR      = 3'd6;
   localparam logic [2:0] F3_AND     = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } issue_state_t;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } rtype_fields_t;

   // An R-type word is legal when the opcode matches and funct7 is either the
   // base encoding or the alternate one, which only exists for SUB and SRA.
   function automatic logic is_legal_rtype(input rtype_fields_t f);
      return (f.opcode == OPC_RTYPE) &&
             ((f.funct7 == F7_BASE) ||
              ((f.funct7 == F7_ALT) &&
               ((f.funct3 == F3_ADD_SUB) || (f.funct3 == F3_SRL_SRA))));
   endfunction

endpackage

// File: rtl/rv32_regfile.sv
// 32x32 integer register file: one synchronous write port, two operand read
// ports and a debug read port, all combinational reads with x0 fixed at 0.
module rv32_regfile
   import rv32_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   output logic [XLEN-1:0] rdata1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata2,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   logic [XLEN-1:0] mem [NREG];

   // Register storage: cleared on reset, written when enabled except for x0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: clearing every entry forces this array into flops instead of a
         // RAM macro; the all-zero state after reset is architecturally visible.
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata1   = (raddr1   == 5'd0) ? '0 : mem[raddr1];
   assign rdata2   = (raddr2   == 5'd0) ? '0 : mem[raddr2];
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/r_type_issue.sv
// Issue/write-back sequencer feeding an external combinational R-type ALU:
// accept, read operands, execute, write back, one instruction per 4 cycles.
module r_type_issue
   import rv32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   input  logic        ld_valid,
   input  logic [4:0]  ld_addr,
   input  logic [31:0] ld_data,
   output logic [6:0]  alu_opcode,
   output logic [2:0]  alu_funct3,
   output logic [6:0]  alu_funct7,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   input  logic [31:0] alu_out,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        illegal,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   issue_state_t  state, state_nx;
   rtype_fields_t ir;
   logic [31:0]   in1_q, in2_q, result_q;
   logic [2:0]    f3_q;
   logic [6:0]    f7_q;
   logic [31:0]   rs1_data, rs2_data;
   logic          legal;
   logic          rf_we;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;
   logic          load_ok;

   assign legal   = is_legal_rtype(ir);
   assign load_ok = (state == IDLE) && ld_valid && !instr_valid;

   // Write port is shared: preloads happen only in IDLE, write-back only in WB.
   assign rf_we    = load_ok || ((state == WB) && (ir.rd != 5'd0));
   assign rf_waddr = (state == WB) ? ir.rd : ld_addr;
   assign rf_wdata = (state == WB) ? result_q : ld_data;

   rv32_regfile u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .raddr1   (ir.rs1),
      .rdata1   (rs1_data),
      .raddr2   (ir.rs2),
      .rdata2   (rs2_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // State register; reset drops any in-flight instruction back to IDLE.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic: illegal words exit from READ straight to IDLE.
   always_comb begin
      // NOTE: default first so no path through the case leaves state_nx
      // unassigned, which would infer a latch.
      state_nx = state;
      case (state)
         IDLE:    if (instr_valid) state_nx = READ;
         READ:    state_nx = legal ? EXEC : IDLE;
         EXEC:    state_nx = WB;
         WB:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath registers: instruction latch, operand/field latches, ALU result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ir       <= '0;
         in1_q    <= '0;
         in2_q    <= '0;
         f3_q     <= '0;
         f7_q     <= '0;
         result_q <= '0;
      end else begin
         if ((state == IDLE) && instr_valid) ir <= instr;
         if ((state == READ) && legal) begin
            in1_q <= rs1_data;
            in2_q <= rs2_data;
            f3_q  <= ir.funct3;
            f7_q  <= ir.funct7;
         end
         if (state == EXEC) result_q <= alu_out;
      end
   end

   // Outputs are forced to their idle values while reset is held.
   assign instr_ready = rst_n && (state == IDLE);
   assign illegal     = rst_n && (state == READ) && !legal;
   assign wb_valid    = rst_n && (state == WB);
   assign wb_rd       = rst_n ? ir.rd    : 5'd0;
   assign wb_data     = rst_n ? result_q : 32'd0;
   assign alu_opcode  = (rst_n && (state == EXEC)) ? ir.opcode : 7'd0;
   assign alu_funct3  = rst_n ? f3_q  : 3'd0;
   assign alu_funct7  = rst_n ? f7_q  : 7'd0;
   assign alu_in1     = rst_n ? in1_q : 32'd0;
   assign alu_in2     = rst_n ? in2_q : 32'd0;

endmodule

// File: tb/tb_r_type_issue.sv
// Directed self-checking bench for r_type_issue with a behavioural R-type
// ALU closing the loop on alu_out.
module tb_r_type_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        ld_valid;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic [6:0]  alu_opcode;
   logic [2:0]  alu_funct3;
   logic [6:0]  alu_funct7;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [31:0] alu_out;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        illegal;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   int nerr = 0;
   int nchk = 0;
   int wb_count = 0;

   always #5 clk = ~clk;

   r_type_issue dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .ld_valid    (ld_valid),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .alu_opcode  (alu_opcode),
      .alu_funct3  (alu_funct3),
      .alu_funct7  (alu_funct7),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_out     (alu_out),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .illegal     (illegal),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   // External ALU stand-in: active only when the R-type opcode is presented.
   always_comb begin
      alu_out = 32'd0;
      if (alu_opcode == 7'h33) begin
         case (alu_funct3)
            3'd0: alu_out = alu_funct7[5] ? alu_in1 - alu_in2 : alu_in1 + alu_in2;
            3'd1: alu_out = alu_in1 << alu_in2[4:0];
            3'd2: alu_out = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
            3'd3: alu_out = {31'd0, alu_in1 < alu_in2};
            3'd4: alu_out = alu_in1 ^ alu_in2;
            3'd5: alu_out = alu_funct7[5] ? 32'($signed(alu_in1) >>> alu_in2[4:0])
                                          : alu_in1 >> alu_in2[4:0];
            3'd6: alu_out = alu_in1 | alu_in2;
            default: alu_out = alu_in1 & alu_in2;
         endcase
      end
   end

   // Write-back pulse counter, sampled mid-cycle.
   always @(negedge clk) if (wb_valid === 1'b1) wb_count++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_valid = 1'b0;
      dbg_addr = a;
      #1 check("preload_dbg", dbg_data, d);
   endtask

   task automatic run_legal(input string tag, input logic [31:0] w,
                            input logic [4:0] rd, input logic [31:0] exp);
      instr = w; instr_valid = 1'b1;
      check({tag, "_ready0"}, instr_ready, 1);
      tick();                               // cycle 1: READ
      instr_valid = 1'b0;
      check({tag, "_c1_illegal"}, illegal, 0);
      check({tag, "_c1_ready"}, instr_ready, 0);
      tick();                               // cycle 2: EXEC
      check({tag, "_c2_opcode"}, alu_opcode, 32'h33);
      check({tag, "_c2_wbv"}, wb_valid, 0);
      tick();                               // cycle 3: WB
      check({tag, "_c3_wbv"}, wb_valid, 1);
      check({tag, "_c3_rd"}, wb_rd, rd);
      check({tag, "_c3_data"}, wb_data, exp);
      check({tag, "_c3_opcode"}, alu_opcode, 0);
      tick();                               // cycle 4: IDLE
      check({tag, "_c4_ready"}, instr_ready, 1);
      check({tag, "_c4_wbv"}, wb_valid, 0);
      dbg_addr = rd;
      #1 check({tag, "_rf"}, dbg_data, (rd == 5'd0) ? 32'd0 : exp);
   endtask

   task automatic run_illegal(input string tag, input logic [31:0] w);
      instr = w; instr_valid = 1'b1;
      tick();                               // cycle 1: READ with pulse
      instr_valid = 1'b0;
      check({tag, "_c1_illegal"}, illegal, 1);
      check({tag, "_c1_opcode"}, alu_opcode, 0);
      tick();                               // back in IDLE
      check({tag, "_c2_illegal"}, illegal, 0);
      check({tag, "_c2_ready"}, instr_ready, 1);
      check({tag, "_c2_wbv"}, wb_valid, 0);
   endtask

   initial begin
      logic [31:0] words [3];
      logic [31:0] exps  [3];
      logic [4:0]  rds   [3];
      int          base;

      rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;

      // Reset held
      tick(); tick();
      check("rst_ready", instr_ready, 0);
      check("rst_wbv", wb_valid, 0);
      check("rst_illegal", illegal, 0);
      check("rst_opcode", alu_opcode, 0);
      check("rst_wbdata", wb_data, 0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", instr_ready, 1);
      check("post_rst_wbrd", wb_rd, 0);
      check("post_rst_f3", alu_funct3, 0);
      check("post_rst_f7", alu_funct7, 0);
      check("post_rst_in1", alu_in1, 0);
      check("post_rst_in2", alu_in2, 0);
      dbg_addr = 5'd31;
      #1 check("post_rst_x31", dbg_data, 0);

      // add x3,x1,x2 with 5 + 7
      preload(5'd1, 32'd5);
      preload(5'd2, 32'd7);
      instr = 32'h002081B3; instr_valid = 1'b1;
      tick(); instr_valid = 1'b0; tick();
      check("add_in1", alu_in1, 32'd5);
      check("add_in2", alu_in2, 32'd7);
      check("add_opcode", alu_opcode, 32'h33);
      tick();
      check("add_wbv", wb_valid, 1);
      check("add_wbrd", wb_rd, 3);
      check("add_wbdata", wb_data, 32'd12);
      tick();
      dbg_addr = 5'd3;
      #1 check("add_x3", dbg_data, 32'd12);

      // sra and sub on a sign-bit operand
      preload(5'd1, 32'h8000_0000);
      preload(5'd2, 32'd4);
      run_legal("sra", 32'h4020D2B3, 5'd5, 32'hF800_0000);
      check("sra_f7", alu_funct7, 32'h20);
      run_legal("sub", 32'h40110333, 5'd6, 32'h8000_0004);

      // rd = x0: pulse but no write
      run_legal("add_x0", 32'h00208033, 5'd0, 32'h8000_0004);

      // Illegal words leave registers and held ALU fields untouched
      run_illegal("addi", 32'h00108393);
      run_illegal("f7alt_xor", 32'h4020C3B3);
      dbg_addr = 5'd7;
      #1 check("illegal_x7", dbg_data, 0);
      check("illegal_f3_hold", alu_funct3, 0);
      check("illegal_in1_hold", alu_in1, 32'h8000_0000);

      // Back-to-back issue with instr_valid held high
      words[0] = 32'h0020E433; rds[0] = 5'd8;  exps[0] = 32'h8000_0004; // or
      words[1] = 32'h0020F4B3; rds[1] = 5'd9;  exps[1] = 32'h0000_0000; // and
      words[2] = 32'h0020A533; rds[2] = 5'd10; exps[2] = 32'h0000_0001; // slt
      base = wb_count;
      instr_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         instr = words[k];
         check("b2b_ready_idle", instr_ready, 1);
         tick(); check("b2b_ready_read", instr_ready, 0);
         tick(); check("b2b_ready_exec", instr_ready, 0);
         tick(); check("b2b_ready_wb", instr_ready, 0);
         check("b2b_wbv", wb_valid, 1);
         check("b2b_wbrd", wb_rd, rds[k]);
         check("b2b_wbdata", wb_data, exps[k]);
         if (k == 2) instr_valid = 1'b0;
         tick();
      end
      check("b2b_ready_end", instr_ready, 1);
      tick(); tick();
      check("b2b_pulses", wb_count - base, 3);
      dbg_addr = 5'd10;
      #1 check("b2b_x10", dbg_data, 1);

      // Reset during EXEC aborts the instruction and clears the file
      instr = 32'h002081B3; instr_valid = 1'b1;
      tick(); instr_valid = 1'b0; tick();
      check("abort_exec_opcode", alu_opcode, 32'h33);
      base = wb_count;
      rst_n = 1'b0;
      #1 check("abort_low_wbv", wb_valid, 0);
      check("abort_low_ready", instr_ready, 0);
      tick();
      rst_n = 1'b1;
      #1 check("abort_ready", instr_ready, 1);
      check("abort_wbv", wb_valid, 0);
      for (int r = 0; r < 32; r++) begin
         dbg_addr = 5'(r);
         #1 check("abort_rf_clear", dbg_data, 0);
      end
      tick(); tick(); tick();
      check("abort_no_wb", wb_count - base, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
